// File: rtl/pc.sv
// Program counter register.
// Loads next_pc on every rising clock edge with the low ALIGN_BITS bits
// cleared, or RESET_VALUE when reset is high at that edge. No arithmetic is
// done here: incrementing, branch targets and wrap-around all belong to the
// caller. current_pc comes straight from the register, so there is no
// combinational path from next_pc or reset to the output.
module pc #(
   parameter int          WIDTH       = 32,
   parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
   parameter int          ALIGN_BITS  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] next_pc,
   output logic [WIDTH-1:0] current_pc
);

   // RESET_VALUE is written as a 32-bit literal; fit it to the register width.
   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

   // Mask that clears the low ALIGN_BITS bits. With ALIGN_BITS = 0 this is
   // all ones, so next_pc passes through unmodified. The AND keeps any X or
   // Z in the unmasked bits, so unknowns on next_pc still reach current_pc.
   localparam logic [WIDTH-1:0] ALIGN_MASK =
      ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));

   logic [WIDTH-1:0] pc_q;

   // PC register: synchronous reset takes priority over the load.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RST_VAL;
      end else begin
         pc_q <= next_pc & ALIGN_MASK;
      end
   end

   assign current_pc = pc_q;

endmodule

// File: tb/tb_pc.sv
// Testbench for pc. Two instances are driven from the same inputs: one with
// the default parameters, and one with ALIGN_BITS = 2 and
// RESET_VALUE = 32'h0040_0000.
// For each vector, the stimulus process pushes the values it expects after
// the next rising edge into a queue. A separate monitor pops and compares
// those values just after every rising edge. Between edges, the stimulus
// process also checks that the outputs hold: first while next_pc changes,
// then while reset pulses high without a clock edge.
module tb_pc;

   logic        clk;
   logic        reset;
   logic [31:0] next_pc;
   logic [31:0] cur_a;
   logic [31:0] cur_b;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } exp_t;

   exp_t exp_q[$];

   typedef struct {
      string       name;
      logic        rst;
      logic [31:0] npc;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   // Expected values are worked out by hand.
   // Instance b clears bits [1:0] on load and resets to 32'h0040_0000.
   vec_t vecs[] = '{
      '{"reset",      1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0040_0000},
      '{"seq_00",     1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000},
      '{"seq_04",     1'b0, 32'h0000_0004, 32'h0000_0004, 32'h0000_0004},
      '{"seq_08",     1'b0, 32'h0000_0008, 32'h0000_0008, 32'h0000_0008},
      '{"seq_0c",     1'b0, 32'h0000_000C, 32'h0000_000C, 32'h0000_000C},
      '{"seq_10",     1'b0, 32'h0000_0010, 32'h0000_0010, 32'h0000_0010},
      '{"seq_14",     1'b0, 32'h0000_0014, 32'h0000_0014, 32'h0000_0014},
      '{"seq_18",     1'b0, 32'h0000_0018, 32'h0000_0018, 32'h0000_0018},
      '{"seq_1c",     1'b0, 32'h0000_001C, 32'h0000_001C, 32'h0000_001C},
      '{"rst_prio",   1'b1, 32'h0000_1000, 32'h0000_0000, 32'h0040_0000},
      '{"load_20",    1'b0, 32'h0000_0020, 32'h0000_0020, 32'h0000_0020},
      '{"load_40",    1'b0, 32'h0000_0040, 32'h0000_0040, 32'h0000_0040},
      '{"wrap_top",   1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC},
      '{"wrap_zero",  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000},
      '{"align_7",    1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0000_0004},
      '{"align_ff",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC},
      '{"align_mix",  1'b0, 32'h1234_5679, 32'h1234_5679, 32'h1234_5678},
      '{"rst_mid",    1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0040_0000},
      '{"resume_3",   1'b0, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000}
   };

   pc u_pc_a (
      .clk        (clk),
      .reset      (reset),
      .next_pc    (next_pc),
      .current_pc (cur_a)
   );

   pc #(
      .WIDTH       (32),
      .RESET_VALUE (32'h0040_0000),
      .ALIGN_BITS  (2)
   ) u_pc_b (
      .clk        (clk),
      .reset      (reset),
      .next_pc    (next_pc),
      .current_pc (cur_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare both instances against the queued expectation just
   // after every rising edge that has one pending.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, "_a"}, cur_a, e.exp_a);
            check({e.name, "_b"}, cur_b, e.exp_b);
         end
      end
   end

   // Stimulus
   initial begin
      logic [31:0] prev_a;
      logic [31:0] prev_b;
      reset   = 1'b1;
      next_pc = 32'h0000_0000;
      prev_a  = '0;
      prev_b  = '0;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset   = vecs[i].rst;
         next_pc = vecs[i].npc;
         exp_q.push_back('{vecs[i].name, vecs[i].exp_a, vecs[i].exp_b});
         if (i > 0) begin
            // next_pc has just changed between edges; the outputs must hold.
            #1;
            check({vecs[i].name, "_hold_a"}, cur_a, prev_a);
            check({vecs[i].name, "_hold_b"}, cur_b, prev_b);
            if (!vecs[i].rst) begin
               // A reset pulse that contains no clock edge must have no effect.
               #1 reset = 1'b1;
               #1;
               check({vecs[i].name, "_glitch_a"}, cur_a, prev_a);
               check({vecs[i].name, "_glitch_b"}, cur_b, prev_b);
               #1 reset = 1'b0;
            end
         end
         prev_a = vecs[i].exp_a;
         prev_b = vecs[i].exp_b;
      end
      repeat (3) @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
